// File: rtl/nco_multi_chan_quad.sv
// nco_multi_chan_quad: NUM_CH quadrature NCO channels, shadowed config port,
// external quarter-wave ROM with sign rebuild. Optional dither: NCO_DITHER_EN.
module nco_multi_chan_quad #(
  parameter int NUM_CH = 4,
  parameter int ACC_W = 32,
  parameter int ROM_AW = 10,
  parameter int OUT_W = 16,
  parameter int ROM_LAT = 2,
  parameter int unsigned DEFAULT_FREQ = 42949672,
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        en,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [2:0]                  cfg_op,
  input  logic [CH_W-1:0]             cfg_ch,
  input  logic [ACC_W-1:0]            cfg_data,
  output logic                        cfg_err,
  output logic                        rd_valid,
  output logic [ACC_W-1:0]            rd_data,
  output logic [NUM_CH*ROM_AW-1:0]    rom_addr_sin,
  output logic [NUM_CH*ROM_AW-1:0]    rom_addr_cos,
  input  logic [NUM_CH*(OUT_W-1)-1:0] rom_q_sin,
  input  logic [NUM_CH*(OUT_W-1)-1:0] rom_q_cos,
  output logic                        out_valid,
  output logic [NUM_CH*OUT_W-1:0]     sin_out,
  output logic [NUM_CH*OUT_W-1:0]     cos_out
);

  localparam int MAG_W = OUT_W - 1;
  localparam int PH_W = ROM_AW + 2;
  localparam int SHIFT = ACC_W - PH_W;
  localparam int DITH_W = ACC_W - ROM_AW - 2;
  localparam logic [ACC_W-1:0] DEF_FREQ = ACC_W'(DEFAULT_FREQ);

  localparam logic [2:0] OP_SET_FREQ = 3'd0;
  localparam logic [2:0] OP_SET_PHASE = 3'd1;
  localparam logic [2:0] OP_ADD_PHASE = 3'd2;
  localparam logic [2:0] OP_COMMIT = 3'd3;
  localparam logic [2:0] OP_READ_ACC = 3'd4;

  logic [ACC_W-1:0] acc [NUM_CH];
  logic [ACC_W-1:0] freq [NUM_CH];
  logic [ACC_W-1:0] freqSh [NUM_CH];
  logic [ACC_W-1:0] off [NUM_CH];
  logic [ACC_W-1:0] offSh [NUM_CH];
  logic [ACC_W-1:0] dith [NUM_CH];
  logic [PH_W-1:0] phTop [NUM_CH];
  logic phValid;

  logic cfgRdy;
  logic accept;
  logic chLegal;
  logic [ACC_W-1:0] accSel;
  logic doSetF, doSetP, doAddP;
  logic doCommit, doRead, doErr;

  assign cfg_ready = cfgRdy & ~RST;
  assign accept = cfg_valid & cfg_ready;

  always_comb begin
    chLegal = 1'b0;
    accSel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg_ch == CH_W'(c)) begin
        chLegal = 1'b1;
        accSel = acc[c];
      end
    end
  end

  // Out-of-range channel is an error for every op except COMMIT.
  always_comb begin
    doSetF = 1'b0;
    doSetP = 1'b0;
    doAddP = 1'b0;
    doCommit = 1'b0;
    doRead = 1'b0;
    doErr = 1'b0;
    if (accept) begin
      unique case (1'b1)
        (cfg_op == OP_COMMIT):
          doCommit = 1'b1;
        (cfg_op > OP_READ_ACC) || !chLegal:
          doErr = 1'b1;
        (cfg_op == OP_SET_FREQ):
          doSetF = 1'b1;
        (cfg_op == OP_SET_PHASE):
          doSetP = 1'b1;
        (cfg_op == OP_ADD_PHASE):
          doAddP = 1'b1;
        (cfg_op == OP_READ_ACC):
          doRead = 1'b1;
      endcase
    end
  end

`ifdef NCO_DITHER_EN
  logic [15:0] lfsr [NUM_CH];

  always_ff @(posedge CLK) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (RST)
        lfsr[c] <= 16'hACE1 ^ 16'(c);
      else if (en)
        lfsr[c] <= {1'b0, lfsr[c][15:1]}
                 ^ (lfsr[c][0] ? 16'hB400 : 16'h0000);
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      dith[c] = '0;
      for (int b = 0; b < 16; b++)
        if (b < DITH_W) dith[c][b] = lfsr[c][b];
    end
  end
`else
  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      dith[c] = '0;
  end
`endif

  // A clearing COMMIT overrides the same-edge increment; the phase
  // sampled on that edge still uses the pre-commit acc and offset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int c = 0; c < NUM_CH; c++) begin
        acc[c] <= '0;
        freq[c] <= DEF_FREQ;
        freqSh[c] <= DEF_FREQ;
        off[c] <= '0;
        offSh[c] <= '0;
        phTop[c] <= '0;
      end
      phValid <= 1'b0;
      cfgRdy <= 1'b0;
      cfg_err <= 1'b0;
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else begin
      phValid <= en;
      cfgRdy <= ~doRead;
      cfg_err <= doErr;
      rd_valid <= doRead;
      if (doRead)
        rd_data <= accSel;
      for (int c = 0; c < NUM_CH; c++) begin
        if (en) begin
          acc[c] <= acc[c] + freq[c];
          phTop[c] <= PH_W'((acc[c] + off[c] + dith[c]) >> SHIFT);
        end
        if (doCommit) begin
          freq[c] <= freqSh[c];
          off[c] <= offSh[c];
          if (cfg_data[0])
            acc[c] <= '0;
        end
        if (cfg_ch == CH_W'(c)) begin
          if (doSetF)
            freqSh[c] <= cfg_data;
          if (doSetP)
            offSh[c] <= cfg_data;
          if (doAddP)
            offSh[c] <= offSh[c] + cfg_data;
        end
      end
    end
  end

  logic [ROM_AW-1:0] foldS [NUM_CH];
  logic [ROM_AW-1:0] foldC [NUM_CH];
  logic [ROM_AW-1:0] addrS [NUM_CH];
  logic [ROM_AW-1:0] addrC [NUM_CH];
  logic [NUM_CH-1:0] foldNegS, foldNegC;
  logic [NUM_CH-1:0] negS, negC;
  logic foldValid;

  // Odd quadrants walk the quarter table backwards.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      foldS[c] = phTop[c][ROM_AW] ? ~phTop[c][ROM_AW-1:0]
                                  : phTop[c][ROM_AW-1:0];
      foldC[c] = phTop[c][ROM_AW] ? phTop[c][ROM_AW-1:0]
                                  : ~phTop[c][ROM_AW-1:0];
      foldNegS[c] = phTop[c][ROM_AW+1];
      foldNegC[c] = phTop[c][ROM_AW+1] ^ phTop[c][ROM_AW];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int c = 0; c < NUM_CH; c++) begin
        addrS[c] <= '0;
        addrC[c] <= '0;
      end
      negS <= '0;
      negC <= '0;
      foldValid <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        addrS[c] <= foldS[c];
        addrC[c] <= foldC[c];
      end
      negS <= foldNegS;
      negC <= foldNegC;
      foldValid <= phValid;
    end
  end

  logic [ROM_LAT-1:0] vldPipe;
  logic [NUM_CH-1:0] negSPipe [ROM_LAT];
  logic [NUM_CH-1:0] negCPipe [ROM_LAT];

  always_ff @(posedge CLK) begin
    if (RST) begin
      vldPipe <= '0;
      for (int j = 0; j < ROM_LAT; j++) begin
        negSPipe[j] <= '0;
        negCPipe[j] <= '0;
      end
    end else begin
      vldPipe[0] <= foldValid;
      negSPipe[0] <= negS;
      negCPipe[0] <= negC;
      for (int j = 1; j < ROM_LAT; j++) begin
        vldPipe[j] <= vldPipe[j-1];
        negSPipe[j] <= negSPipe[j-1];
        negCPipe[j] <= negCPipe[j-1];
      end
    end
  end

  logic [OUT_W-1:0] sinNext [NUM_CH];
  logic [OUT_W-1:0] cosNext [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [MAG_W-1:0] magS, magC;
    assign rom_addr_sin[c*ROM_AW +: ROM_AW] = addrS[c];
    assign rom_addr_cos[c*ROM_AW +: ROM_AW] = addrC[c];
    assign magS = rom_q_sin[c*MAG_W +: MAG_W];
    assign magC = rom_q_cos[c*MAG_W +: MAG_W];
    assign sinNext[c] = negSPipe[ROM_LAT-1][c] ? -{1'b0, magS}
                                               : {1'b0, magS};
    assign cosNext[c] = negCPipe[ROM_LAT-1][c] ? -{1'b0, magC}
                                               : {1'b0, magC};
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      out_valid <= 1'b0;
      sin_out <= '0;
      cos_out <= '0;
    end else begin
      out_valid <= vldPipe[ROM_LAT-1];
      if (vldPipe[ROM_LAT-1]) begin
        for (int c = 0; c < NUM_CH; c++) begin
          sin_out[c*OUT_W +: OUT_W] <= sinNext[c];
          cos_out[c*OUT_W +: OUT_W] <= cosNext[c];
        end
      end
    end
  end

endmodule

// File: tb/tb_nco_multi_chan_quad.sv
// tb_nco_multi_chan_quad: directed + random bench with a trig-level
// reference model and a behavioural quarter-wave ROM.
module tb_nco_multi_chan_quad;
  localparam int NCH = 4;
  localparam int LAT = 2;
  localparam int DEF = 42949672;
  localparam real PI = 3.14159265358979323846;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic en = 1'b0;
  logic cfg_valid = 1'b0;
  logic [2:0] cfg_op = '0;
  logic [1:0] cfg_ch = '0;
  logic [31:0] cfg_data = '0;
  logic cfg_ready, cfg_err, rd_valid, out_valid;
  logic [31:0] rd_data;
  logic [39:0] rom_addr_sin, rom_addr_cos;
  logic [59:0] rom_q_sin, rom_q_cos;
  logic [63:0] sin_out, cos_out;

  always #5 CLK = ~CLK;

  nco_multi_chan_quad #(
    .NUM_CH(NCH), .ACC_W(32), .ROM_AW(10), .OUT_W(16),
    .ROM_LAT(LAT), .DEFAULT_FREQ(DEF)
  ) dut (
    .CLK(CLK), .RST(RST), .en(en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_op(cfg_op), .cfg_ch(cfg_ch), .cfg_data(cfg_data),
    .cfg_err(cfg_err), .rd_valid(rd_valid), .rd_data(rd_data),
    .rom_addr_sin(rom_addr_sin), .rom_addr_cos(rom_addr_cos),
    .rom_q_sin(rom_q_sin), .rom_q_cos(rom_q_cos),
    .out_valid(out_valid), .sin_out(sin_out), .cos_out(cos_out)
  );

  logic [14:0] romTab [1024];
  logic [59:0] romS [LAT];
  logic [59:0] romC [LAT];

  always @(posedge CLK) begin
    for (int c = 0; c < NCH; c++) begin
      romS[0][c*15 +: 15] <= romTab[rom_addr_sin[c*10 +: 10]];
      romC[0][c*15 +: 15] <= romTab[rom_addr_cos[c*10 +: 10]];
    end
    for (int j = 1; j < LAT; j++) begin
      romS[j] <= romS[j-1];
      romC[j] <= romC[j-1];
    end
  end
  assign rom_q_sin = romS[LAT-1];
  assign rom_q_cos = romC[LAT-1];

  int nChecks = 0;
  int nFail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  logic [31:0] mAcc [NCH];
  logic [31:0] mFreq [NCH];
  logic [31:0] mFreqSh [NCH];
  logic [31:0] mOff [NCH];
  logic [31:0] mOffSh [NCH];
  bit expV [8];
  logic [15:0] expSin [8][NCH];
  logic [15:0] expCos [8][NCH];
  bit mReady = 1'b0;
  bit mErr = 1'b0;
  bit mRdV = 1'b0;
  logic [31:0] mRdData = '0;
  int cyc = 0;

  // Ideal wave at the centre of the 2^12-step phase bin, rounded half away.
  function automatic logic [15:0] waveVal(input logic [31:0] ph,
                                          input bit isCos);
    real x, v;
    x = 2.0 * PI * (real'(int'(ph[31:20])) + 0.5) / 4096.0;
    v = 32767.0 * (isCos ? $cos(x) : $sin(x));
    if (v >= 0.0) return 16'($rtoi(v + 0.5));
    return 16'(-$rtoi(0.5 - v));
  endfunction

  task automatic modelEdge();
    logic [31:0] nAcc [NCH];
    int slot;
    bit acc_;
    cyc++;
    if (RST) begin
      for (int c = 0; c < NCH; c++) begin
        mAcc[c] = '0;
        mFreq[c] = DEF;
        mFreqSh[c] = DEF;
        mOff[c] = '0;
        mOffSh[c] = '0;
      end
      for (int s = 0; s < 8; s++) expV[s] = 1'b0;
      mReady = 1'b0;
      mErr = 1'b0;
      mRdV = 1'b0;
      return;
    end
    acc_ = cfg_valid && mReady;
    mErr = 1'b0;
    mRdV = 1'b0;
    mReady = 1'b1;
    for (int c = 0; c < NCH; c++)
      nAcc[c] = en ? mAcc[c] + mFreq[c] : mAcc[c];
    if (en) begin
      slot = (cyc + LAT + 2) % 8;
      expV[slot] = 1'b1;
      for (int c = 0; c < NCH; c++) begin
        expSin[slot][c] = waveVal(mAcc[c] + mOff[c], 1'b0);
        expCos[slot][c] = waveVal(mAcc[c] + mOff[c], 1'b1);
      end
    end
    if (acc_) begin
      case (cfg_op)
        3'd0: mFreqSh[cfg_ch] = cfg_data;
        3'd1: mOffSh[cfg_ch] = cfg_data;
        3'd2: mOffSh[cfg_ch] = mOffSh[cfg_ch] + cfg_data;
        3'd3: begin
          for (int c = 0; c < NCH; c++) begin
            mFreq[c] = mFreqSh[c];
            mOff[c] = mOffSh[c];
            if (cfg_data[0]) nAcc[c] = '0;
          end
        end
        3'd4: begin
          mRdData = mAcc[cfg_ch];
          mRdV = 1'b1;
          mReady = 1'b0;
        end
        default: mErr = 1'b1;
      endcase
    end
    mAcc = nAcc;
  endtask

  always @(negedge CLK) begin
    int s;
    s = cyc % 8;
    chk("cfg_ready", 64'(cfg_ready), 64'(mReady && !RST));
    chk("cfg_err", 64'(cfg_err), 64'(mErr));
    chk("rd_valid", 64'(rd_valid), 64'(mRdV));
    if (mRdV) chk("rd_data", 64'(rd_data), 64'(mRdData));
    chk("out_valid", 64'(out_valid), 64'(expV[s]));
    if (expV[s]) begin
      for (int c = 0; c < NCH; c++) begin
        chk($sformatf("sin_out[%0d]", c), 64'(sin_out[c*16 +: 16]),
            64'(expSin[s][c]));
        chk($sformatf("cos_out[%0d]", c), 64'(cos_out[c*16 +: 16]),
            64'(expCos[s][c]));
      end
    end
    expV[s] = 1'b0;
  end

  task automatic tick(input bit r, input bit e, input bit v,
                      input logic [2:0] op, input logic [1:0] ch,
                      input logic [31:0] d);
    RST = r;
    en = e;
    cfg_valid = v;
    cfg_op = op;
    cfg_ch = ch;
    cfg_data = d;
    @(posedge CLK);
    modelEdge();
    #1;
  endtask

  task automatic idle();
    tick(0, 0, 0, 3'd0, 2'd0, 32'd0);
  endtask

  task automatic readChk(input logic [1:0] ch, input logic [31:0] exp,
                         input string nm);
    tick(0, 0, 1, 3'd4, ch, 32'd0);
    chk({nm, "_rd_valid"}, 64'(rd_valid), 64'd1);
    chk({nm, "_rd_data"}, 64'(rd_data), 64'(exp));
    chk({nm, "_ready_low"}, 64'(cfg_ready), 64'd0);
    idle();
    chk({nm, "_ready_back"}, 64'(cfg_ready), 64'd1);
    chk({nm, "_rd_pulse"}, 64'(rd_valid), 64'd0);
  endtask

  initial begin
    logic [15:0] lit1 [4];
    lit1 = '{16'h0019, 16'h7FFF, 16'hFFE7, 16'h8001};
    for (int i = 0; i < 1024; i++)
      romTab[i] = 15'($rtoi(32767.0 * $sin(PI / 2.0 * (real'(i) + 0.5)
                                                / 1024.0) + 0.5));
    for (int c = 0; c < NCH; c++) begin
      mAcc[c] = '0; mFreq[c] = DEF; mFreqSh[c] = DEF;
      mOff[c] = '0; mOffSh[c] = '0;
    end
    for (int s = 0; s < 8; s++) expV[s] = 1'b0;

    tick(1, 0, 0, 3'd0, 2'd0, 32'd0);
    tick(1, 0, 0, 3'd0, 2'd0, 32'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sin_out", sin_out, 64'd0);
    chk("rst_cos_out", cos_out, 64'd0);
    chk("rst_rom_addr", 64'(rom_addr_sin), 64'd0);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    idle();
    chk("rel_cfg_ready", 64'(cfg_ready), 64'd1);

    // quarter-turn steps on ch0
    tick(0, 0, 1, 3'd0, 2'd0, 32'h4000_0000);
    tick(0, 0, 1, 3'd3, 2'd0, 32'd1);
    for (int t = 0; t < 8; t++) begin
      tick(0, 1, 0, 3'd0, 2'd0, 32'd0);
      if (t >= 1)
        chk("t1_addr_sin0", 64'(rom_addr_sin[9:0]),
            64'(((t - 1) % 2 == 1) ? 1023 : 0));
      if (t == 3) chk("t1_latency_lo", 64'(out_valid), 64'd0);
      if (t >= 4) begin
        chk("t1_out_valid", 64'(out_valid), 64'd1);
        chk("t1_sin0", 64'(sin_out[15:0]), 64'(lit1[(t - 4) % 4]));
      end
    end

    // shadowed freq is invisible until COMMIT
    tick(0, 0, 1, 3'd3, 2'd0, 32'd1);
    tick(0, 0, 1, 3'd0, 2'd1, 32'h8000_0000);
    repeat (3) tick(0, 1, 0, 3'd0, 2'd0, 32'd0);
    readChk(2'd1, 32'(3 * DEF), "t2_pre");
    tick(0, 0, 1, 3'd3, 2'd0, 32'd1);
    repeat (3) tick(0, 1, 0, 3'd0, 2'd0, 32'd0);
    readChk(2'd1, 32'h8000_0000, "t2_post");
    readChk(2'd0, 32'hC000_0000, "t2_ch0");
    readChk(2'd3, 32'(3 * DEF), "t2_ch3");

    // clearing COMMIT coincident with en
    tick(0, 0, 1, 3'd0, 2'd0, 32'd100);
    tick(0, 1, 1, 3'd3, 2'd0, 32'd1);
    readChk(2'd0, 32'd0, "t3_clear");
    repeat (5) tick(0, 1, 0, 3'd0, 2'd0, 32'd0);
    readChk(2'd0, 32'd500, "t3_500");

    // phase offset into quadrant 2
    tick(0, 0, 1, 3'd1, 2'd2, 32'h4000_0000);
    tick(0, 0, 1, 3'd2, 2'd2, 32'h4000_0000);
    tick(0, 0, 1, 3'd0, 2'd2, 32'd0);
    tick(0, 0, 1, 3'd3, 2'd0, 32'd1);
    tick(0, 1, 0, 3'd0, 2'd0, 32'd0);
    repeat (4) idle();
    chk("t4_out_valid", 64'(out_valid), 64'd1);
    chk("t4_sin2", 64'(sin_out[47:32]), 64'h0000_0000_0000_FFE7);
    chk("t4_cos2", 64'(cos_out[47:32]), 64'h0000_0000_0000_8001);

    // illegal ops
    for (int k = 5; k < 8; k++) begin
      tick(0, 0, 1, 3'(k), 2'd2, 32'd12345);
      chk("t5_cfg_err", 64'(cfg_err), 64'd1);
    end
    idle();
    chk("t5_err_pulse", 64'(cfg_err), 64'd0);
    readChk(2'd2, 32'd0, "t5_nochange");

    // reset mid-stream
    repeat (3) tick(0, 1, 0, 3'd0, 2'd0, 32'd0);
    tick(1, 1, 0, 3'd0, 2'd0, 32'd0);
    chk("t6_out_valid", 64'(out_valid), 64'd0);
    chk("t6_ready_rst", 64'(cfg_ready), 64'd0);
    idle();
    chk("t6_ready_rel", 64'(cfg_ready), 64'd1);
    tick(0, 1, 0, 3'd0, 2'd0, 32'd0);
    readChk(2'd0, 32'(DEF), "t6_deffreq");

    for (int n = 0; n < 4000; n++) begin
      logic [2:0] op;
      int w;
      w = int'($urandom_range(0, 15));
      if (w < 4) op = 3'd0;
      else if (w < 7) op = 3'd1;
      else if (w < 10) op = 3'd2;
      else if (w < 12) op = 3'd3;
      else if (w < 14) op = 3'd4;
      else op = 3'($urandom_range(5, 7));
      tick($urandom_range(0, 599) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 2) == 0, op, 2'($urandom_range(0, 3)),
           $urandom);
    end
    repeat (8) idle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
